// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the iterative M-extension unit.
// ALUOP codes, FSM state encoding and operand signedness helpers.
package rv32_pkg;

    localparam logic [4:0] ALU_MUL    = 5'b01000;
    localparam logic [4:0] ALU_MULH   = 5'b01001;
    localparam logic [4:0] ALU_MULHSU = 5'b01010;
    localparam logic [4:0] ALU_MULHU  = 5'b01011;
    localparam logic [4:0] ALU_DIV    = 5'b01100;
    localparam logic [4:0] ALU_DIVU   = 5'b01101;
    localparam logic [4:0] ALU_REM    = 5'b01110;
    localparam logic [4:0] ALU_REMU   = 5'b01111;

    localparam int unsigned ITER_COUNT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic logic op_signed1(input logic [4:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) ||
               (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic op_signed2(input logic [4:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) ||
               (op == ALU_DIV) || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/mul_div_datapath.sv
// 64-bit accumulator with one shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle, plus final sign correction.
module mul_div_datapath
    import rv32_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_load_acc,
    input  logic [31:0] i_load_opb,
    input  logic [4:0]  i_op,
    input  logic        i_neg_lo,
    input  logic        i_neg_hi,
    output logic [31:0] o_result
);

    logic [63:0] r_acc;
    logic [31:0] r_opb;

    logic [32:0] w_sum;
    logic [33:0] w_diff;
    logic [63:0] w_acc_next;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    // Divide: the shifted partial remainder needs 33 bits when the divisor exceeds 2^31.
    always_comb begin
        w_sum  = {1'b0, r_acc[63:32]} + {1'b0, r_opb};
        w_diff = {1'b0, r_acc[63:31]} - {2'b00, r_opb};
        if (i_op[2]) begin
            w_acc_next = w_diff[33] ? {r_acc[62:0], 1'b0}
                                    : {w_diff[31:0], r_acc[30:0], 1'b1};
        end else if (r_acc[0]) begin
            w_acc_next = {w_sum, r_acc[31:1]};
        end else begin
            w_acc_next = {1'b0, r_acc[63:1]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
            r_opb <= '0;
        end else if (i_load) begin
            r_acc <= {32'd0, i_load_acc};
            r_opb <= i_load_opb;
        end else if (i_step) begin
            r_acc <= w_acc_next;
        end
    end

    always_comb begin
        w_prod = i_neg_lo ? -r_acc : r_acc;
        w_quo  = i_neg_lo ? -r_acc[31:0] : r_acc[31:0];
        w_rem  = i_neg_hi ? -r_acc[63:32] : r_acc[63:32];
        case (i_op)
            ALU_MUL:                         o_result = w_prod[31:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: o_result = w_prod[63:32];
            ALU_DIV, ALU_DIVU:               o_result = w_quo;
            default:                         o_result = w_rem;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// RV32M iterative multiply/divide unit: control FSM, operand latching and
// handshake around mul_div_datapath. Fixed 33-cycle accept-to-DONE latency.
module mul_div_unit
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      ALUOP,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic [4:0]      DEST_IN,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT,
    output logic [4:0]      DEST_OUT
);

    state_t            r_state;
    logic [4:0]        r_count;
    logic [4:0]        r_op;
    logic [4:0]        r_dest;
    logic              r_neg_lo;
    logic              r_neg_hi;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_dest_out;

    logic              w_accept;
    logic              w_s1;
    logic              w_s2;
    logic              w_is_div;
    logic              w_dbz;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic [XLEN-1:0]   w_load_acc;
    logic [XLEN-1:0]   w_load_opb;
    logic [XLEN-1:0]   w_result;

    always_comb begin
        w_accept   = (r_state == IDLE) && START && !FLUSH && (ALUOP[4:3] == 2'b01);
        w_s1       = op_signed1(ALUOP) && OPERAND1[XLEN-1];
        w_s2       = op_signed2(ALUOP) && OPERAND2[XLEN-1];
        w_mag1     = w_s1 ? -OPERAND1 : OPERAND1;
        w_mag2     = w_s2 ? -OPERAND2 : OPERAND2;
        w_is_div   = ALUOP[2];
        w_dbz      = w_is_div && (OPERAND2 == '0);
        w_load_acc = w_is_div ? w_mag1 : w_mag2;
        w_load_opb = w_is_div ? w_mag2 : w_mag1;
    end

    mul_div_datapath u_datapath (
        .i_clk      (CLK),
        .i_rst      (RESET),
        .i_load     (w_accept),
        .i_step     (r_state == RUN),
        .i_load_acc (w_load_acc),
        .i_load_opb (w_load_opb),
        .i_op       (r_op),
        .i_neg_lo   (r_neg_lo),
        .i_neg_hi   (r_neg_hi),
        .o_result   (w_result)
    );

    // Divide-by-zero leaves the all-ones quotient magnitude un-negated.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_op       <= '0;
            r_dest     <= '0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_dest_out <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= RUN;
                        r_busy   <= 1'b1;
                        r_count  <= '0;
                        r_op     <= ALUOP;
                        r_dest   <= DEST_IN;
                        r_neg_lo <= (w_s1 ^ w_s2) && !w_dbz;
                        r_neg_hi <= w_s1;
                    end
                end
                RUN: begin
                    if (FLUSH) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (r_count == 5'(ITER_COUNT - 1)) begin
                            r_state <= FINISH;
                        end
                        r_count <= r_count + 5'd1;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (!FLUSH) begin
                        r_done     <= 1'b1;
                        r_result   <= w_result;
                        r_dest_out <= r_dest;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign RESULT   = r_result;
    assign DEST_OUT = r_dest_out;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors push expected results,
// a negedge monitor pops and checks result, tag and 33-cycle latency on DONE.
module tb_mul_div_unit;
    import rv32_pkg::*;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [4:0]  ALUOP;
    logic [31:0] OPERAND1;
    logic [31:0] OPERAND2;
    logic [4:0]  DEST_IN;
    logic        FLUSH;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;
    logic [4:0]  DEST_OUT;

    mul_div_unit #(.XLEN(32)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .ALUOP    (ALUOP),
        .OPERAND1 (OPERAND1),
        .OPERAND2 (OPERAND2),
        .DEST_IN  (DEST_IN),
        .FLUSH    (FLUSH),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .RESULT   (RESULT),
        .DEST_OUT (DEST_OUT)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  dest;
        int          acc;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  d;
        logic [31:0] e;
    } vec_t;

    exp_t q[$];
    vec_t vecs[16];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_done = 0;
    int   cyc = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (DONE) begin
            n_done++;
            if (q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", RESULT, e.res);
                chk("dest_out", {27'd0, DEST_OUT}, {27'd0, e.dest});
                chk("latency", 32'(cyc - e.acc), 32'd33);
            end
        end
    end

    // Called at #1 after a rising edge with the unit idle; returns the accept cycle.
    task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] d, input bit hold, output int acc);
        START    = 1'b1;
        ALUOP    = op;
        OPERAND1 = a;
        OPERAND2 = b;
        DEST_IN  = d;
        @(posedge CLK); #1;
        acc = cyc;
        if (!hold) START = 1'b0;
        OPERAND1 = 32'hDEAD_BEEF;
        OPERAND2 = 32'h0000_0003;
        DEST_IN  = 5'd31;
    endtask

    task automatic push_exp(input logic [31:0] res, input logic [4:0] d, input int acc);
        exp_t e;
        e.res  = res;
        e.dest = d;
        e.acc  = acc;
        q.push_back(e);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 60 && q.size() != 0; i++) begin
            if (!DONE) chk("busy_in_flight", {31'd0, BUSY}, 32'd1);
            @(posedge CLK); #1;
        end
        chk("drain_timeout", q.size(), 32'd0);
        @(posedge CLK); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        START = 0; ALUOP = '0; OPERAND1 = '0; OPERAND2 = '0; DEST_IN = '0; FLUSH = 0;
        RESET = 1'b1;

        vecs[0]  = '{ALU_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFEB};
        vecs[1]  = '{ALU_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000};
        vecs[2]  = '{ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
        vecs[3]  = '{ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF};
        vecs[4]  = '{ALU_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD};
        vecs[5]  = '{ALU_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFF};
        vecs[6]  = '{ALU_DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'h7FFF_FFFC};
        vecs[7]  = '{ALU_REMU,   32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'h0000_0001};
        vecs[8]  = '{ALU_DIV,    32'h0000_0005, 32'h0000_0000, 5'd8,  32'hFFFF_FFFF};
        vecs[9]  = '{ALU_REMU,   32'h0000_0005, 32'h0000_0000, 5'd10, 32'h0000_0005};
        vecs[10] = '{ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000};
        vecs[11] = '{ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000};
        vecs[12] = '{ALU_MUL,    32'h1234_5678, 32'h0000_0010, 5'd13, 32'h2345_6780};
        vecs[13] = '{ALU_DIV,    32'hFFFF_FFFB, 32'h0000_0000, 5'd14, 32'hFFFF_FFFF};
        vecs[14] = '{ALU_REM,    32'hFFFF_FFFB, 32'h0000_0000, 5'd15, 32'hFFFF_FFFB};
        vecs[15] = '{ALU_REMU,   32'hFFFF_FFFF, 32'h8000_0000, 5'd16, 32'h7FFF_FFFF};

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_busy", {31'd0, BUSY}, 32'd0);
        chk("reset_done", {31'd0, DONE}, 32'd0);
        chk("reset_result", RESULT, 32'd0);
        chk("reset_dest", {27'd0, DEST_OUT}, 32'd0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        for (int i = 0; i < 16; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, 1'b0, acc);
            push_exp(vecs[i].e, vecs[i].d, acc);
            drain();
        end

        // START held through BUSY with different operands must not disturb the first op.
        start_op(ALU_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd9, 1'b1, acc);
        push_exp(32'hFFFF_FFEB, 5'd9, acc);
        ALUOP = ALU_DIV; OPERAND1 = 32'h0000_0064; OPERAND2 = 32'h0000_0005; DEST_IN = 5'd20;
        repeat (20) @(posedge CLK);
        #1;
        START = 1'b0;
        drain();

        // Flush at acc+10, restart at acc+12.
        start_op(ALU_DIVU, 32'h0000_0064, 32'h0000_0007, 5'd3, 1'b0, acc);
        while (cyc < acc + 9) begin
            @(posedge CLK); #1;
        end
        chk("busy_before_flush", {31'd0, BUSY}, 32'd1);
        FLUSH = 1'b1;
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        chk("flush_busy", {31'd0, BUSY}, 32'd0);
        chk("flush_done", {31'd0, DONE}, 32'd0);
        chk("flush_result_hold", RESULT, 32'hFFFF_FFEB);
        chk("flush_dest_hold", {27'd0, DEST_OUT}, 32'd9);
        @(posedge CLK); #1;
        start_op(ALU_MULHU, 32'h0001_0000, 32'h0001_0000, 5'd20, 1'b0, acc);
        push_exp(32'h0000_0001, 5'd20, acc);
        drain();

        // Reset mid-divide at acc+20.
        start_op(ALU_DIV, 32'h0000_03E8, 32'hFFFF_FFF9, 5'd7, 1'b0, acc);
        while (cyc < acc + 19) begin
            @(posedge CLK); #1;
        end
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        chk("midreset_busy", {31'd0, BUSY}, 32'd0);
        chk("midreset_done", {31'd0, DONE}, 32'd0);
        chk("midreset_result", RESULT, 32'd0);
        chk("midreset_dest", {27'd0, DEST_OUT}, 32'd0);

        // Non-M opcode, then FLUSH together with START: neither may be accepted.
        begin
            int done_before;
            done_before = n_done;
            START = 1'b1; ALUOP = 5'b00000; OPERAND1 = 32'd6; OPERAND2 = 32'd7;
            @(posedge CLK); #1;
            chk("nonm_busy", {31'd0, BUSY}, 32'd0);
            ALUOP = ALU_MUL; FLUSH = 1'b1;
            @(posedge CLK); #1;
            chk("flush_start_busy", {31'd0, BUSY}, 32'd0);
            START = 1'b0; FLUSH = 1'b0;
            repeat (40) @(posedge CLK);
            #1;
            chk("no_done_after_reject", 32'(n_done - done_before), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide execution unit in the EX stage, downstream of the control unit.
- Consumes the 5-bit ALUOP codes 01000–01111 together with the two ALU operands.
- Produces a 32-bit result after a fixed multi-cycle latency, plus a BUSY signal the hazard logic uses to stall IF/ID/EX.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge
- RESET  input  1  synchronous, active-high reset
- START  input  1  request; sampled only in IDLE
- ALUOP  input  5  M-op select: 01000 MUL, 01001 MULH, 01010 MULHSU, 01011 MULHU, 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU
- OPERAND1  input  32  rs1 value (multiplicand / dividend)
- OPERAND2  input  32  rs2 value (multiplier / divisor)
- DEST_IN  input  5  rd tag, carried through to writeback
- FLUSH  input  1  abort the in-flight operation (branch/jump flush)
- BUSY  output  1  high while an operation is in flight; drives the pipeline stall
- DONE  output  1  one-cycle pulse; RESULT and DEST_OUT are valid this cycle
- RESULT  output  32  final result; holds its value until the next DONE
- DEST_OUT  output  5  latched rd tag

Behaviour:
- Reset: state IDLE, BUSY=0, DONE=0, RESULT=0, DEST_OUT=0, all internal registers 0. Reset has priority over START and FLUSH in every state, including mid-operation.
- States: IDLE, RUN, FINISH.
- IDLE -> RUN when START=1, ALUOP[4:3]=01 and FLUSH=0 (acceptance edge = cycle 0).
  - At acceptance: latch op, DEST_IN, operand magnitudes and result sign.
  - START with ALUOP[4:3]!=01 is ignored: no state change, BUSY stays 0.
- BUSY=1 in RUN and FINISH.
- RUN: 32 iterations, one per cycle, counter 0..31.
  - Multiply: unsigned shift-add on magnitudes into a 64-bit product.
  - Divide: unsigned restoring shift-subtract on magnitudes, producing quotient and remainder.
  - After iteration 31: go to FINISH.
- FINISH: apply sign correction (two's-complement negate), select the result word, assert DONE, then return to IDLE.
  - DONE is high for exactly the cycle following the 33rd edge after acceptance. Fixed latency: 33 cycles from accept to DONE.
- Back-to-back: START is sampled again only in IDLE; the earliest next accept is the edge after the DONE cycle. START while BUSY is ignored, with no queuing.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: OPERAND1 signed, OPERAND2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Result sign rules:
  - Product sign = XOR of the operand signs (signed operands only).
  - Quotient sign = XOR of the operand signs.
  - Remainder sign = dividend sign.
- Result select: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
- Divide by zero (detected at accept, flagged):
  - Quotient = 0xFFFFFFFF for both DIV and DIVU.
  - Remainder = dividend, unmodified.
  - Latency still 33 cycles.
- Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0; latency unchanged.
- FLUSH in RUN or FINISH: next state IDLE, BUSY=0 next cycle, DONE never asserted, RESULT and DEST_OUT retain their previous values. FLUSH in IDLE blocks acceptance that cycle.
- Simultaneous FLUSH and START in IDLE: FLUSH wins; nothing is accepted.
- DONE and FLUSH in the same cycle: DONE is already registered, so the result is delivered. Discarding it is the pipeline's responsibility.
- Operand inputs may change freely after the acceptance edge.

Decomposition:
- Shared package rv32_pkg holds:
  - ALUOP localparams (ALU_MUL..ALU_REMU, 5'b01000..5'b01111).
  - State encoding (IDLE=2'd0, RUN=2'd1, FINISH=2'd2).
  - ITER_COUNT=32.
- One sub-module, mul_div_datapath:
  - Holds the 64-bit accumulator/remainder register, the shift/add/subtract step and the final negation mux.
  - mul_div_unit keeps the FSM, counter, latches and handshake.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3), START at cycle 0 -> BUSY=1 for cycles 1–33, DONE at cycle 33, RESULT=0xFFFFFFEB; DEST_IN=5'd9 gives DEST_OUT=9.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC; REMU 0xFFFFFFF9 / 2 -> 1.
- DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; each with DONE at cycle 33.
- START held high during BUSY with new operands -> ignored and the original result is delivered. FLUSH at cycle 10 -> BUSY=0 at cycle 11, no DONE, RESULT unchanged. New START at cycle 12 completes normally at cycle 45.
- RESET asserted at cycle 20 mid-DIV -> cycle 21: BUSY=0, DONE=0, RESULT=0, DEST_OUT=0. START with ALUOP=5'b00000 -> BUSY stays 0 and no DONE ever occurs.
